// File: rtl/spi_cfg_pkg.sv
// Shared state encoding, init-table word layout and the latched SPI command type
// for the SPI configuration sequencer.
package spi_cfg_pkg;

  localparam int TBL_W    = 18;
  localparam int END_BIT  = 17;
  localparam int ADDR_MSB = 16;
  localparam int ADDR_LSB = 8;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    POR_WAIT, FETCH, ISSUE, WAIT_TBL, HOST_IDLE, WAIT_HOST, ERROR
  } state_t;

  typedef struct packed {
    logic       rd;
    logic [8:0] addr;
    logic [7:0] din;
  } spi_req_t;

  function automatic logic tbl_end(input logic [TBL_W-1:0] w);
    return w[END_BIT];
  endfunction

  function automatic logic [8:0] tbl_reg(input logic [TBL_W-1:0] w);
    return w[ADDR_MSB:ADDR_LSB];
  endfunction

  function automatic logic [7:0] tbl_val(input logic [TBL_W-1:0] w);
    return w[DATA_MSB:DATA_LSB];
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Handshake bundle between the sequencer and the SPI master it drives.
interface spi_cfg_sequencer_if;
  logic       spi_strobe;
  logic       spi_ce;
  logic       spi_rd;
  logic [8:0] spi_addr;
  logic [7:0] spi_din;
  logic       spi_ack;
  logic [7:0] spi_rdata;

  modport master (output spi_strobe, spi_ce, spi_rd, spi_addr, spi_din,
                  input  spi_ack, spi_rdata);
  modport slave  (input  spi_strobe, spi_ce, spi_rd, spi_addr, spi_din,
                  output spi_ack, spi_rdata);
endinterface

// File: rtl/spi_ack_timer.sv
// Saturating ack-timeout counter; clear takes priority over counting.
module spi_ack_timer #(
  parameter int W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic sat
);
  logic [W-1:0] cnt;

  assign sat = &cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (en && !sat) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/spi_cfg_sequencer.sv
// Replays an init table over SPI after power-on, then serves single host
// register reads/writes; any ack timeout parks the block in ERROR until reset.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int TBL_AW  = 6,
  parameter int POR_CYC = 1000,
  parameter int TMO_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [TBL_W-1:0]  tbl_data,
  input  logic              host_req,
  input  logic              host_rd,
  input  logic [8:0]        host_addr,
  input  logic [7:0]        host_din,
  output logic              host_ack,
  output logic [7:0]        host_rdata,
  output logic              host_busy,
  spi_cfg_sequencer_if.master spi,
  output logic              init_done,
  output logic              init_err
);
  localparam int PW = (POR_CYC > 1) ? $clog2(POR_CYC) : 1;

  state_t   state, state_nxt;
  logic [PW-1:0] por_cnt;
  logic     fetch_ph;
  spi_req_t cmd;
  logic     strobe, ce;
  logic     tmo_sat, wait_st, tbl_last;
  logic     load_tbl, load_host, ack_tbl, ack_host, timeout, done_set;

  assign wait_st   = (state == WAIT_TBL) || (state == WAIT_HOST);
  assign tbl_last  = &tbl_addr;
  assign host_busy = (state != HOST_IDLE);

  assign spi.spi_strobe = strobe;
  assign spi.spi_ce     = ce;
  assign spi.spi_rd     = cmd.rd;
  assign spi.spi_addr   = cmd.addr;
  assign spi.spi_din    = cmd.din;

  spi_ack_timer #(.W(TMO_W)) u_tmr (
    .clk   (clk),
    .rst   (rst),
    .clear (strobe),
    .en    (wait_st),
    .sat   (tmo_sat)
  );

  always_comb begin
    state_nxt = state;
    load_tbl  = 1'b0;
    load_host = 1'b0;
    ack_tbl   = 1'b0;
    ack_host  = 1'b0;
    timeout   = 1'b0;
    done_set  = 1'b0;
    unique case (state)
      POR_WAIT: if (por_cnt == PW'(POR_CYC - 1)) state_nxt = FETCH;
      // first FETCH cycle lets the table read settle, second one decides
      FETCH: if (fetch_ph) begin
        if (tbl_end(tbl_data)) begin
          state_nxt = HOST_IDLE;
          done_set  = 1'b1;
        end else begin
          state_nxt = ISSUE;
          load_tbl  = 1'b1;
        end
      end
      ISSUE: state_nxt = WAIT_TBL;
      WAIT_TBL: begin
        if (spi.spi_ack) begin
          ack_tbl = 1'b1;
          if (tbl_last) begin
            state_nxt = HOST_IDLE;
            done_set  = 1'b1;
          end else begin
            state_nxt = FETCH;
          end
        end else if (tmo_sat) begin
          timeout   = 1'b1;
          state_nxt = ERROR;
        end
      end
      HOST_IDLE: if (host_req) begin
        load_host = 1'b1;
        state_nxt = WAIT_HOST;
      end
      // the host_ack cycle stays here so the next request lands after it;
      // the strobe cycle still sees the previous count, hence the gate
      WAIT_HOST: begin
        if (host_ack) state_nxt = HOST_IDLE;
        else if (spi.spi_ack) ack_host = 1'b1;
        else if (tmo_sat && !strobe) begin
          timeout   = 1'b1;
          state_nxt = ERROR;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= POR_WAIT;
      por_cnt    <= '0;
      fetch_ph   <= 1'b0;
      tbl_addr   <= '0;
      cmd        <= '0;
      strobe     <= 1'b0;
      ce         <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_ph <= (state == FETCH) && !fetch_ph;
      strobe   <= load_tbl | load_host;
      host_ack <= ack_host | (timeout && state == WAIT_HOST);
      if (state == POR_WAIT) por_cnt <= por_cnt + 1'b1;
      if (load_tbl) begin
        cmd <= '{rd: 1'b0, addr: tbl_reg(tbl_data), din: tbl_val(tbl_data)};
        ce  <= 1'b1;
      end
      if (load_host) begin
        cmd <= '{rd: host_rd, addr: host_addr, din: host_din};
        ce  <= 1'b1;
      end
      if (ack_tbl || ack_host || timeout) ce <= 1'b0;
      if (ack_tbl) tbl_addr <= tbl_addr + 1'b1;
      if (ack_host && cmd.rd) host_rdata <= spi.spi_rdata;
      if (timeout && state == WAIT_HOST) host_rdata <= 8'hFF;
      if (done_set) init_done <= 1'b1;
      if (timeout) init_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench: expected SPI commands and host read data are queued by the
// stimulus thread and consumed by a monitor whenever the DUT strobes or acks.
module tb_spi_cfg_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  tbl_addr;
  logic [17:0] tbl_data = '0;
  logic        host_req = 1'b0, host_rd = 1'b0;
  logic [8:0]  host_addr = '0;
  logic [7:0]  host_din = '0;
  logic        host_ack, host_busy, init_done, init_err;
  logic [7:0]  host_rdata;

  spi_cfg_sequencer_if sif ();

  spi_cfg_sequencer #(.TBL_AW(6), .POR_CYC(4), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .host_req(host_req), .host_rd(host_rd), .host_addr(host_addr),
    .host_din(host_din), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_busy(host_busy), .spi(sif.master), .init_done(init_done),
    .init_err(init_err)
  );

  always #5 clk = ~clk;

  logic [17:0] rom [64];
  always @(posedge clk) tbl_data <= rom[tbl_addr];

  // SPI slave model
  logic auto_ack = 1'b0, man_ack = 1'b0;
  bit   ack_en = 1'b1;
  int   ack_dly = 2;
  logic [7:0] slave_rdata = '0;
  assign sif.spi_ack = auto_ack | man_ack;

  initial begin
    sif.spi_rdata = '0;
    forever begin
      @(negedge clk);
      if (sif.spi_strobe === 1'b1 && ack_en) begin
        repeat (ack_dly) @(posedge clk);
        #1 auto_ack = 1'b1;
        sif.spi_rdata = slave_rdata;
        @(posedge clk);
        #1 auto_ack = 1'b0;
      end
    end
  end

  int checks = 0, errors = 0;
  int ack_cnt = 0, strobe_cnt = 0;
  logic [17:0] exp_spi [$];
  logic [7:0]  exp_host [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] tword(input bit e, input logic [8:0] a, input logic [7:0] d);
    return {e, a, d};
  endfunction

  // monitor
  logic prev_ack = 1'b0, prev_ack_ce = 1'b0;
  always @(negedge clk) begin
    if (sif.spi_strobe === 1'b1) begin
      strobe_cnt++;
      if (exp_spi.size() == 0) begin
        checks++; errors++;
        $display("FAIL spi_unexp: got strobe addr %0h din %0h, expected none", sif.spi_addr, sif.spi_din);
      end else begin
        check("spi_cmd", {14'd0, sif.spi_rd, sif.spi_addr, sif.spi_din}, {14'd0, exp_spi.pop_front()});
        check("spi_ce_at_strobe", sif.spi_ce, 1);
      end
    end
    if (host_ack === 1'b1) begin
      if (exp_host.size() == 0) begin
        checks++; errors++;
        $display("FAIL host_ack_unexp: got host_ack rdata %0h, expected none", host_rdata);
      end else begin
        check("host_rdata", host_rdata, exp_host.pop_front());
        check("host_ack_lat", prev_ack, 1);
        check("busy_at_ack", host_busy, 1);
      end
    end
    if (prev_ack_ce) check("ce_drop", sif.spi_ce, 0);
    if (sif.spi_ack === 1'b1) ack_cnt++;
    prev_ack    = sif.spi_ack;
    prev_ack_ce = sif.spi_ack && sif.spi_ce;
  end

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic host_op(input bit rd, input logic [8:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    host_req = 1'b1; host_rd = rd; host_addr = a; host_din = d;
    @(posedge clk); #1 host_req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int n = 0;
    while (init_done !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    check(name, init_done, 1);
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (sif.spi_strobe !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check(name, sif.spi_strobe, 1);
  endtask

  task automatic wait_host_ack(input string name);
    int n = 0;
    while (host_ack !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check(name, host_ack, 1);
  endtask

  task automatic load_small_table();
    for (int i = 0; i < 64; i++) rom[i] = tword(1'b1, 9'h0, 8'h0);
    rom[0] = tword(1'b0, 9'h014, 8'h01);
    rom[1] = tword(1'b0, 9'h0FF, 8'h01);
  endtask

  initial begin
    load_small_table();
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_strobe", sif.spi_strobe, 0);
    check("rst_ce", sif.spi_ce, 0);
    check("rst_spi_addr", {sif.spi_rd, sif.spi_addr, sif.spi_din}, 0);
    check("rst_host", {host_ack, host_rdata}, 0);
    check("rst_flags", {init_done, init_err}, 0);
    check("rst_busy", host_busy, 1);

    // table of two writes; host requests during init are dropped
    exp_spi.push_back(tword(1'b0, 9'h014, 8'h01));
    exp_spi.push_back(tword(1'b0, 9'h0FF, 8'h01));
    ack_cnt = 0;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    host_op(1'b1, 9'h1AA, 8'h00);
    repeat (5) @(posedge clk);
    host_op(1'b0, 9'h0AA, 8'h33);
    wait_done("init_done_small", 200);
    check("acks_at_done", ack_cnt, 2);
    check("tbl_addr_end", tbl_addr, 2);
    check("spi_exp_drained", exp_spi.size(), 0);
    check("init_err_clean", init_err, 0);
    @(negedge clk);
    check("busy_idle", host_busy, 0);

    // host read, then a write that must leave host_rdata unchanged
    slave_rdata = 8'hC3;
    exp_spi.push_back(tword(1'b1, 9'h001, 8'h00));
    exp_host.push_back(8'hC3);
    host_op(1'b1, 9'h001, 8'h00);
    wait_host_ack("host_rd_ack");
    slave_rdata = 8'h11;
    exp_spi.push_back(tword(1'b0, 9'h055, 8'hA5));
    exp_host.push_back(8'hC3);
    host_op(1'b0, 9'h055, 8'hA5);
    wait_host_ack("host_wr_ack");
    repeat (3) @(negedge clk);
    check("rdata_hold", host_rdata, 8'hC3);

    // reset while waiting on a table ack; stale ack must be ignored
    ack_en = 1'b0;
    do_reset();
    exp_spi.push_back(tword(1'b0, 9'h014, 8'h01));
    wait_strobe("strobe_before_rst");
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; man_ack = 1'b1;
    @(posedge clk); #1 man_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("stale_tbl_addr", tbl_addr, 0);
    check("stale_ce", sif.spi_ce, 0);
    check("stale_flags", {init_done, init_err}, 0);
    ack_en = 1'b1;
    ack_cnt = 0;
    exp_spi.push_back(tword(1'b0, 9'h014, 8'h01));
    exp_spi.push_back(tword(1'b0, 9'h0FF, 8'h01));
    wait_done("init_done_restart", 200);
    check("restart_acks", ack_cnt, 2);

    // ack withheld: timeout into ERROR
    ack_en = 1'b0;
    do_reset();
    exp_spi.push_back(tword(1'b0, 9'h014, 8'h01));
    wait_strobe("strobe_tmo");
    begin
      bit early = 1'b0;
      for (int i = 0; i < 15; i++) begin
        @(negedge clk);
        if (init_err !== 1'b0) early = 1'b1;
      end
      check("tmo_not_early", early, 0);
    end
    repeat (2) @(negedge clk);
    check("tmo_init_err", init_err, 1);
    check("tmo_ce", sif.spi_ce, 0);
    check("tmo_done", init_done, 0);
    host_op(1'b1, 9'h002, 8'h00);
    repeat (10) @(negedge clk);
    check("tmo_busy", host_busy, 1);
    check("tmo_err_sticky", init_err, 1);

    // full 64-entry table with no end word
    ack_en = 1'b1;
    ack_dly = 1;
    for (int i = 0; i < 64; i++) begin
      logic [8:0] a;
      logic [7:0] d;
      a = 9'(i * 3);
      d = 8'(i) ^ 8'h5A;
      rom[i] = tword(1'b0, a, d);
    end
    do_reset();
    for (int i = 0; i < 64; i++) exp_spi.push_back(rom[i]);
    ack_cnt = 0;
    strobe_cnt = 0;
    wait_done("init_done_full", 1500);
    check("full_acks", ack_cnt, 64);
    repeat (20) @(negedge clk);
    check("full_strobes", strobe_cnt, 64);
    check("full_tbl_wrap", tbl_addr, 0);
    check("full_flags", {init_err, host_busy}, 0);
    check("final_spi_q", exp_spi.size(), 0);
    check("final_host_q", exp_host.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
